// File: rtl/hack_io_pkg.sv
// hack_io_pkg: shared PS/2 FSM encoding, prefix bytes, Hack key codes and keyboard address
package hack_io_pkg;
  typedef enum logic [2:0] {PS2_IDLE, PS2_DATA, PS2_PARITY, PS2_STOP, PS2_DECODE} ps2_state_t;
  localparam logic [7:0] PS2_EXT = 8'hE0;
  localparam logic [7:0] PS2_BRK = 8'hF0;
  localparam logic [15:0] KEY_NEWLINE   = 16'd128;
  localparam logic [15:0] KEY_BACKSPACE = 16'd129;
  localparam logic [15:0] KEY_LEFT      = 16'd130;
  localparam logic [15:0] KEY_UP        = 16'd131;
  localparam logic [15:0] KEY_RIGHT     = 16'd132;
  localparam logic [15:0] KEY_DOWN      = 16'd133;
  localparam logic [15:0] KEY_HOME      = 16'd134;
  localparam logic [15:0] KEY_END       = 16'd135;
  localparam logic [15:0] KEY_PGUP      = 16'd136;
  localparam logic [15:0] KEY_PGDN      = 16'd137;
  localparam logic [15:0] KEY_INSERT    = 16'd138;
  localparam logic [15:0] KEY_DELETE    = 16'd139;
  localparam logic [15:0] KEY_ESC       = 16'd140;
  localparam logic [15:0] KEY_F1        = 16'd141;
  localparam logic [15:0] KEY_F12       = 16'd152;
  localparam logic [14:0] KBD_ADDR      = 15'h6000;
endpackage

// File: rtl/hack_ps2_keymap.sv
// hack_ps2_keymap: combinational PS/2 set-2 scan code to Hack key code translation
module hack_ps2_keymap
  import hack_io_pkg::*;
(
  input  logic        ext,
  input  logic [7:0]  scancode,
  output logic [15:0] code
);
  always_comb begin
    code = '0;
    if (ext)
      case (scancode)
        8'h6B: code = KEY_LEFT;
        8'h75: code = KEY_UP;
        8'h74: code = KEY_RIGHT;
        8'h72: code = KEY_DOWN;
        8'h6C: code = KEY_HOME;
        8'h69: code = KEY_END;
        8'h7D: code = KEY_PGUP;
        8'h7A: code = KEY_PGDN;
        8'h70: code = KEY_INSERT;
        8'h71: code = KEY_DELETE;
        default: code = '0;
      endcase
    else
      case (scancode)
        8'h1C: code = 16'd65;
        8'h32: code = 16'd66;
        8'h21: code = 16'd67;
        8'h23: code = 16'd68;
        8'h24: code = 16'd69;
        8'h2B: code = 16'd70;
        8'h34: code = 16'd71;
        8'h33: code = 16'd72;
        8'h43: code = 16'd73;
        8'h3B: code = 16'd74;
        8'h42: code = 16'd75;
        8'h4B: code = 16'd76;
        8'h3A: code = 16'd77;
        8'h31: code = 16'd78;
        8'h44: code = 16'd79;
        8'h4D: code = 16'd80;
        8'h15: code = 16'd81;
        8'h2D: code = 16'd82;
        8'h1B: code = 16'd83;
        8'h2C: code = 16'd84;
        8'h3C: code = 16'd85;
        8'h2A: code = 16'd86;
        8'h1D: code = 16'd87;
        8'h22: code = 16'd88;
        8'h35: code = 16'd89;
        8'h1A: code = 16'd90;
        8'h45: code = 16'd48;
        8'h16: code = 16'd49;
        8'h1E: code = 16'd50;
        8'h26: code = 16'd51;
        8'h25: code = 16'd52;
        8'h2E: code = 16'd53;
        8'h36: code = 16'd54;
        8'h3D: code = 16'd55;
        8'h3E: code = 16'd56;
        8'h46: code = 16'd57;
        8'h29: code = 16'd32;
        8'h5A: code = KEY_NEWLINE;
        8'h66: code = KEY_BACKSPACE;
        8'h76: code = KEY_ESC;
        8'h05: code = KEY_F1;
        8'h06: code = 16'd142;
        8'h04: code = 16'd143;
        8'h0C: code = 16'd144;
        8'h03: code = 16'd145;
        8'h0B: code = 16'd146;
        8'h83: code = 16'd147;
        8'h0A: code = 16'd148;
        8'h01: code = 16'd149;
        8'h09: code = 16'd150;
        8'h78: code = 16'd151;
        8'h07: code = KEY_F12;
        default: code = '0;
      endcase
  end
endmodule

// File: rtl/hack_ps2_keyboard.sv
// hack_ps2_keyboard: PS/2 frame receiver and make/break tracker driving the Hack keyboard word
module hack_ps2_keyboard
  import hack_io_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  output logic [15:0] key,
  output logic        key_valid,
  output logic        frame_err
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [SYNC_STAGES-1:0] r_clk_sync, r_data_sync;
  logic                   r_clk_prev, r_parity, r_ext, r_brk;
  logic [3:0]             r_bit_cnt;
  logic [7:0]             r_shift;
  logic [TW-1:0]          r_to;
  ps2_state_t             r_state, w_next;
  logic [15:0]            w_code;
  logic                   w_fall, w_bit, w_timeout, w_bad_frame, w_err;
  assign w_fall      = r_clk_prev & ~r_clk_sync[SYNC_STAGES-1];
  assign w_bit       = r_data_sync[SYNC_STAGES-1];
  assign w_timeout   = (r_state != PS2_IDLE) && (r_to == TW'(TIMEOUT_CYCLES));
  assign w_bad_frame = (r_state == PS2_STOP) && w_fall && !(w_bit && ^{r_shift, r_parity});
  assign w_err       = w_timeout || w_bad_frame;
  hack_ps2_keymap u_keymap (.ext(r_ext), .scancode(r_shift), .code(w_code));
  always_comb begin
    w_next = r_state;
    if (w_timeout) w_next = PS2_IDLE;
    else
      case (r_state)
        PS2_IDLE:   w_next = (w_fall && !w_bit) ? PS2_DATA : PS2_IDLE;
        PS2_DATA:   w_next = (w_fall && r_bit_cnt == 4'd8) ? PS2_PARITY : PS2_DATA;
        PS2_PARITY: w_next = w_fall ? PS2_STOP : PS2_PARITY;
        PS2_STOP:   w_next = !w_fall ? PS2_STOP : w_bad_frame ? PS2_IDLE : PS2_DECODE;
        default:    w_next = PS2_IDLE;
      endcase
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_clk_sync  <= '1;
      r_data_sync <= '1;
      r_clk_prev  <= 1'b1;
      r_state     <= PS2_IDLE;
      r_bit_cnt   <= '0;
      r_shift     <= '0;
      r_parity    <= 1'b0;
      r_ext       <= 1'b0;
      r_brk       <= 1'b0;
      r_to        <= '0;
      key         <= '0;
      key_valid   <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      r_clk_sync  <= {r_clk_sync[SYNC_STAGES-2:0], ps2_clk};
      r_data_sync <= {r_data_sync[SYNC_STAGES-2:0], ps2_data};
      r_clk_prev  <= r_clk_sync[SYNC_STAGES-1];
      r_state     <= w_next;
      r_to        <= w_fall ? '0 : (r_to == TW'(TIMEOUT_CYCLES)) ? r_to : r_to + 1'b1;
      frame_err   <= w_err;
      key_valid   <= 1'b0;
      if (r_state == PS2_IDLE && w_fall && !w_bit) r_bit_cnt <= 4'd1;
      if (r_state == PS2_DATA && w_fall) begin
        r_shift   <= {w_bit, r_shift[7:1]};
        r_bit_cnt <= r_bit_cnt + 4'd1;
      end
      if (r_state == PS2_PARITY && w_fall) r_parity <= w_bit;
      if (w_err) begin
        r_ext <= 1'b0;
        r_brk <= 1'b0;
      end else if (r_state == PS2_DECODE) begin
        if (r_shift == PS2_EXT) r_ext <= 1'b1;
        else if (r_shift == PS2_BRK) r_brk <= 1'b1;
        else begin
          r_ext <= 1'b0;
          r_brk <= 1'b0;
          // a break only releases the key it names; repeats of the held key stay silent
          if (!r_brk && w_code != '0 && w_code != key) begin
            key       <= w_code;
            key_valid <= 1'b1;
          end else if (r_brk && w_code != '0 && w_code == key) begin
            key       <= '0;
            key_valid <= 1'b1;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_hack_ps2_keyboard.sv
// tb_hack_ps2_keyboard: randomized PS/2 frame stimulus checked against a behavioural key model
module tb_hack_ps2_keyboard;
  localparam int TO = 300;
  localparam int H  = 8;
  logic        clk = 1'b0, reset = 1'b0, ps2_clk = 1'b1, ps2_data = 1'b1;
  logic [15:0] key;
  logic        key_valid, frame_err;
  int          checks = 0, errors = 0, kv_cnt = 0, fe_cnt = 0;
  logic [15:0] m_key = '0;
  logic        m_kv = 1'b0, m_fe = 1'b0, m_fe_dc = 1'b0, m_ext = 1'b0, m_brk = 1'b0, chk_en = 1'b0;
  logic [15:0] map_n [256];
  logic [15:0] map_e [256];
  logic [7:0]  letters [26] = '{8'h1C,8'h32,8'h21,8'h23,8'h24,8'h2B,8'h34,8'h33,8'h43,8'h3B,8'h42,8'h4B,8'h3A,
                                 8'h31,8'h44,8'h4D,8'h15,8'h2D,8'h1B,8'h2C,8'h3C,8'h2A,8'h1D,8'h22,8'h35,8'h1A};
  logic [7:0]  digits [10]  = '{8'h45,8'h16,8'h1E,8'h26,8'h25,8'h2E,8'h36,8'h3D,8'h3E,8'h46};
  logic [7:0]  fkeys [12]   = '{8'h05,8'h06,8'h04,8'h0C,8'h03,8'h0B,8'h83,8'h0A,8'h01,8'h09,8'h78,8'h07};
  logic [7:0]  extk [10]    = '{8'h6B,8'h75,8'h74,8'h72,8'h6C,8'h69,8'h7D,8'h7A,8'h70,8'h71};
  logic [7:0]  pool [20]    = '{8'h1C,8'h32,8'h29,8'h5A,8'h66,8'h76,8'h05,8'h07,8'h6B,8'h75,
                                 8'h74,8'h72,8'h6C,8'h69,8'h7D,8'h7A,8'h70,8'h71,8'h45,8'h46};

  hack_ps2_keyboard #(.SYNC_STAGES(2), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .key(key), .key_valid(key_valid), .frame_err(frame_err));

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (key_valid) kv_cnt++;
    if (frame_err) fe_cnt++;
    if (chk_en) begin
      check("key", key, m_key);
      check("key_valid", 16'(key_valid), 16'(m_kv));
      if (!m_fe_dc) check("frame_err", 16'(frame_err), 16'(m_fe));
    end
  end

  task automatic model_decode(input logic [7:0] b);
    logic [15:0] c, nk;
    nk = m_key;
    if (b == 8'hE0) m_ext = 1'b1;
    else if (b == 8'hF0) m_brk = 1'b1;
    else begin
      c = m_ext ? map_e[b] : map_n[b];
      if (!m_brk && c != 0) nk = c;
      else if (m_brk && c != 0 && c == m_key) nk = '0;
      m_ext = 1'b0;
      m_brk = 1'b0;
    end
    m_kv  = (nk != m_key);
    m_key = nk;
  endtask

  task automatic ps2_bit(input logic b);
    ps2_data = b;
    repeat (H) @(posedge clk);
    #1 ps2_clk = 1'b0;
    repeat (H) @(posedge clk);
    #1 ps2_clk = 1'b1;
  endtask

  // model updates are placed on the exact cycles the outputs must change after the stop-bit fall
  task automatic send_frame(input logic [7:0] b, input logic bad_par);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit(~^b ^ bad_par);
    ps2_data = 1'b1;
    repeat (H) @(posedge clk);
    #1 ps2_clk = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    if (bad_par) begin
      m_fe  = 1'b1;
      m_ext = 1'b0;
      m_brk = 1'b0;
    end
    @(posedge clk);
    #1 m_fe = 1'b0;
    if (!bad_par) model_decode(b);
    @(posedge clk);
    #1 m_kv = 1'b0;
    repeat (H - 5) @(posedge clk);
    #1 ps2_clk = 1'b1;
  endtask

  task automatic send_partial(input int nbits);
    int n;
    ps2_bit(1'b0);
    repeat (nbits) ps2_bit(1'($urandom_range(0, 1)));
    m_fe_dc = 1'b1;
    n = 0;
    while (n < TO + 100 && !frame_err) begin
      @(negedge clk);
      n++;
    end
    check("timeout_err", 16'(frame_err), 16'd1);
    m_ext = 1'b0;
    m_brk = 1'b0;
    @(posedge clk);
    #1 m_fe_dc = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog actual=running required=finished");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    int k0, f0, r;
    logic [7:0] b;
    for (int i = 0; i < 256; i++) begin
      map_n[i] = '0;
      map_e[i] = '0;
    end
    for (int i = 0; i < 26; i++) map_n[letters[i]] = 16'(65 + i);
    for (int i = 0; i < 10; i++) map_n[digits[i]] = 16'(48 + i);
    for (int i = 0; i < 12; i++) map_n[fkeys[i]] = 16'(141 + i);
    for (int i = 0; i < 10; i++) map_e[extk[i]] = 16'(130 + i);
    map_n[8'h29] = 16'd32;
    map_n[8'h5A] = 16'd128;
    map_n[8'h66] = 16'd129;
    map_n[8'h76] = 16'd140;
    repeat (3) @(posedge clk);
    #1;
    check("rst_key", key, 16'd0);
    check("rst_kv", 16'(key_valid), 16'd0);
    check("rst_fe", 16'(frame_err), 16'd0);
    reset = 1'b1;
    chk_en = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    k0 = kv_cnt;
    send_frame(8'h1C, 1'b0);
    check("make_a", key, 16'd65);
    check("make_a_pulses", 16'(kv_cnt - k0), 16'd1);
    k0 = kv_cnt;
    send_frame(8'h1C, 1'b0);
    check("typematic_a", key, 16'd65);
    check("typematic_pulses", 16'(kv_cnt - k0), 16'd0);
    k0 = kv_cnt;
    send_frame(8'hF0, 1'b0);
    send_frame(8'h1C, 1'b0);
    check("break_a", key, 16'd0);
    check("break_a_pulses", 16'(kv_cnt - k0), 16'd1);
    send_frame(8'hE0, 1'b0);
    send_frame(8'h75, 1'b0);
    check("ext_up", key, 16'd131);
    send_frame(8'hE0, 1'b0);
    send_frame(8'hF0, 1'b0);
    send_frame(8'h75, 1'b0);
    check("ext_up_break", key, 16'd0);
    send_frame(8'h1C, 1'b0);
    k0 = kv_cnt;
    send_frame(8'hF0, 1'b0);
    send_frame(8'h32, 1'b0);
    check("break_other", key, 16'd65);
    check("break_other_pulses", 16'(kv_cnt - k0), 16'd0);
    f0 = fe_cnt;
    send_frame(8'h29, 1'b1);
    check("bad_parity_key", key, 16'd65);
    check("bad_parity_err", 16'(fe_cnt - f0), 16'd1);
    send_frame(8'h5A, 1'b0);
    check("enter", key, 16'd128);
    send_frame(8'hF0, 1'b0);
    send_frame(8'h5A, 1'b0);
    send_partial(5);
    send_frame(8'hE0, 1'b0);
    send_partial(3);
    k0 = kv_cnt;
    send_frame(8'h6B, 1'b0);
    check("ext_cleared", key, 16'd0);
    check("ext_cleared_pulses", 16'(kv_cnt - k0), 16'd0);
    send_frame(8'h1C, 1'b0);
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2_data = 1'b0;
    repeat (2) @(posedge clk);
    #1 ps2_clk = 1'b0;
    @(posedge clk);
    #2 reset = 1'b0;
    m_key = '0;
    m_ext = 1'b0;
    m_brk = 1'b0;
    #1 check("async_reset_key", key, 16'd0);
    ps2_clk = 1'b1;
    ps2_data = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    send_frame(8'h05, 1'b0);
    check("f1_after_reset", key, 16'd141);
    for (int n = 0; n < 80; n++) begin
      r = $urandom_range(0, 19);
      b = pool[$urandom_range(0, 19)];
      if (r < 4) b = 8'hF0;
      else if (r < 6) b = 8'hE0;
      else if (r == 6) b = 8'($urandom);
      if (r == 7) send_frame(b, 1'b1);
      else if (r == 8) send_partial($urandom_range(1, 9));
      else send_frame(b, 1'b0);
      repeat ($urandom_range(0, 20)) @(posedge clk);
      #1;
    end
    repeat (5) @(posedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/hack_ps2_keyboard.md
Name: hack_ps2_keyboard

Overview:
PS/2 keyboard front end for the Hack computer. It deserialises PS/2 set-2 scan-code frames, tracks make, break and extended prefixes, and translates them to Hack key codes. It drives the 16-bit keyboard word that hack_memory returns at address 24576 (0x6000). It sits upstream of the memory map and supplies the keyboard probing that the memory block leaves out.

Parameters:
SYNC_STAGES, 2, flip-flop depth of the synchroniser on ps2_clk and ps2_data (minimum 2).
TIMEOUT_CYCLES, 100000, clk cycles with no ps2_clk falling edge before a partial frame is abandoned (2 ms at 50 MHz).

Ports:
clk  in  1  system clock.
reset  in  1  asynchronous, active-low reset.
ps2_clk  in  1  raw PS/2 clock from the pin; asynchronous.
ps2_data  in  1  raw PS/2 data from the pin; asynchronous.
key  out  16  Hack key code of the currently held key; 0 when no key is held. Feeds the keyboard word in hack_memory.
key_valid  out  1  one-cycle pulse on any change of key.
frame_err  out  1  one-cycle pulse on a framing, parity or timeout error.

Behaviour:
- Reset: asynchronous and active-low. While reset=0 the following hold:
  - key=0, key_valid=0, frame_err=0.
  - Synchroniser flops=1, bit counter=0, shift register=0.
  - break_pending=0, ext_pending=0, FSM in IDLE.
- Reset asserted mid-frame discards the partial frame.
- Input path: both inputs pass through SYNC_STAGES flops. A falling-edge strobe fires when the synchronised ps2_clk goes from 1 to 0, one cycle after the last sync stage. All sampling happens on this strobe.
- Frame: 11 bits, LSB first: start=0, data[7:0], odd parity, stop=1.
- FSM states:
  - IDLE: on a strobe with data=0, go to DATA with bit counter=1. On a strobe with data=1 (spurious start), stay in IDLE with no error.
  - DATA: shift one data bit per strobe. After bit 8, go to PARITY.
  - PARITY: latch the parity bit, go to STOP.
  - STOP: on the strobe, check stop=1 and that the 9 bits (data plus parity) have an odd count of 1s. Pass goes to DECODE; fail pulses frame_err and goes to IDLE.
  - DECODE: one cycle, processes the byte, returns to IDLE.
- Timeout: a free-running counter clears on every strobe. If it reaches TIMEOUT_CYCLES in any state other than IDLE, the FSM pulses frame_err, clears both pending flags and returns to IDLE.
- Any frame error also clears break_pending and ext_pending.
- DECODE rules for byte b:
  - b=0xE0: set ext_pending. key is unchanged.
  - b=0xF0: set break_pending. key is unchanged.
  - Otherwise: look up code=map(ext_pending, b), then clear both flags.
    - Make with code≠0: key=code. Typematic repeats of the same code leave key unchanged and do not pulse key_valid.
    - Break with code==key: key=0.
    - Break of a different key, or code==0 (unmapped byte): key unchanged.
- Latency: key and key_valid update on the clk edge that ends DECODE, i.e. 2 cycles after the stop-bit strobe.
- key_valid fires only when the new key differs from the old key.
- key[15:8] is always 0.
- Keymap, non-extended:
  - Letters A–Z give 65–90 (set-2 codes: 1C,32,21,23,24,2B,34,33,43,3B,42,4B,3A,31,44,4D,15,2D,1B,2C,3C,2A,1D,22,35,1A).
  - Digits 0–9 give 48–57 (45,16,1E,26,25,2E,36,3D,3E,46).
  - Space 29 gives 32.
  - Enter 5A gives 128.
  - Backspace 66 gives 129.
  - Esc 76 gives 140.
  - F1–F12 (05,06,04,0C,03,0B,83,0A,01,09,78,07) give 141–152.
- Keymap, extended (after E0):
  - Left 6B → 130; up 75 → 131; right 74 → 132; down 72 → 133.
  - Home 6C → 134; end 69 → 135; pgup 7D → 136; pgdn 7A → 137.
  - Insert 70 → 138; delete 71 → 139.
- Everything else maps to 0.

Decomposition:
- A shared package, hack_io_pkg, holds:
  - the PS/2 FSM state encoding;
  - the prefix constants 0xE0 and 0xF0;
  - the Hack key-code constants (KEY_NEWLINE=128 … KEY_F12=152);
  - KBD_ADDR=15'h6000.
- Sub-module hack_ps2_keymap is purely combinational: inputs ext and scancode[7:0], output code[15:0]. The FSM, synchroniser and timeout stay in hack_ps2_keyboard.

Test Plan:
- After reset, send frame 0x1C (A) with correct parity → key=65, one key_valid pulse 2 cycles after the stop strobe. Send 0x1C again (typematic) → key=65, no pulse.
- Send F0,1C → key=0 with a key_valid pulse. Then send E0,75 → key=131. Then E0,F0,75 → key=0.
- Press 0x1C, then send break F0,32 (B) → key stays 65, no pulse.
- Send 0x29 with parity bit inverted → frame_err pulse, key unchanged. Next good frame 0x5A → key=128.
- Send start plus 5 data bits, then hold ps2_clk high for TIMEOUT_CYCLES → frame_err pulse. Then send E0 followed by a timeout, then 0x6B → key=0 (non-extended 6B is unmapped, proving ext_pending was cleared).
- With key=65, assert reset mid-frame for 3 cycles → key=0 immediately (asynchronously). After release, a good frame 0x05 → key=141.
